// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU and its downstream result stage.
// Flag layout is {V,P,Zr,CY,S}, bit4..bit0.
package alu_pkg;

  localparam int ALU_W  = 16;
  localparam int FLAG_W = 5;

  localparam int FLG_S  = 0;
  localparam int FLG_CY = 1;
  localparam int FLG_ZR = 2;
  localparam int FLG_P  = 3;
  localparam int FLG_V  = 4;

  typedef struct packed {
    logic [ALU_W-1:0]  z;
    logic [FLAG_W-1:0] flags;
  } alu_result_t;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic v, input logic p,
                                                   input logic zr, input logic cy,
                                                   input logic s);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLG_V]  = v;
    f[FLG_P]  = p;
    f[FLG_ZR] = zr;
    f[FLG_CY] = cy;
    f[FLG_S]  = s;
    return f;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Generic 2-entry valid/ready buffer. in_ready depends only on registered
// occupancy, so there is no combinational path from out_ready to in_ready.
module skid_fifo2 #(
  parameter int W     = 21,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [W-1:0] mem [2];
  logic [W-1:0] last_pop;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // When empty the outputs keep showing the most recently popped entry.
  assign out_data  = out_valid ? mem[rd_ptr] : last_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      last_pop <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        last_pop <= mem[rd_ptr];
        rd_ptr   <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage after the ALU: buffers {Z, flags} in a 2-entry skid
// FIFO and keeps sticky carry/overflow status plus an accepted-result counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  Z,
  input  logic              S,
  input  logic              CY,
  input  logic              Zr,
  input  logic              P,
  input  logic              V,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_z,
  output logic [FLAG_W-1:0] out_flags,
  output logic              sticky_cy,
  output logic              sticky_v,
  input  logic              clr_sticky,
  output logic [CNT_W-1:0]  res_count
);

  localparam int EW = WIDTH + FLAG_W;

  logic [EW-1:0] in_entry;
  logic [EW-1:0] head;
  logic          push;

  assign in_entry  = {Z, pack_flags(V, P, Zr, CY, S)};
  assign push      = in_valid && in_ready;
  assign out_z     = head[EW-1:FLAG_W];
  assign out_flags = head[FLAG_W-1:0];

  skid_fifo2 #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  // A set from an accepted push takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_cy <= 1'b0;
      sticky_v  <= 1'b0;
      res_count <= '0;
    end else begin
      sticky_cy <= (sticky_cy && !clr_sticky) || (push && CY);
      sticky_v  <= (sticky_v  && !clr_sticky) || (push && V);
      if (push) res_count <= res_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered downstream stage for the 16-bit ALU.
- Captures the ALU result Z and its flags (S, CY, Zr, P, V) into a 2-entry skid/FIFO buffer.
- Uses a valid/ready handshake on both sides, so the writeback consumer can stall without dropping results.
- Keeps sticky carry/overflow status and a count of accepted results, for software-visible status.

Parameters:
- WIDTH, 16, data width of the result path. Must match the ALU.
- DEPTH, 2, buffer entries. Fixed at 2 (skid). Other values are unsupported.
- CNT_W, 8, width of the accepted-result counter.

Ports:
- clk  in  1  Rising-edge clock, single domain.
- rst_n  in  1  Synchronous, active-low reset.
- in_valid  in  1  The ALU result on Z/flags is valid this cycle.
- in_ready  out  1  The stage can accept a result this cycle.
- Z  in  WIDTH  ALU sum.
- S  in  1  Sign flag.
- CY  in  1  Carry-out flag.
- Zr  in  1  Zero flag.
- P  in  1  Even-parity flag.
- V  in  1  Signed-overflow flag.
- out_valid  out  1  out_z/out_flags hold a buffered result.
- out_ready  in  1  The consumer takes the head entry this cycle.
- out_z  out  WIDTH  Head-entry result.
- out_flags  out  5  Head-entry flags packed {V,P,Zr,CY,S}, bit4..bit0.
- sticky_cy  out  1  Set by any accepted result with CY=1.
- sticky_v  out  1  Set by any accepted result with V=1.
- clr_sticky  in  1  Clears both sticky bits.
- res_count  out  CNT_W  Number of accepted results, modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. All state changes occur only on the rising edge of clk.
- Reset (rst_n=0 at a clock edge): occupancy=0, read/write pointers=0, out_valid=0, out_z=0, out_flags=0, sticky_cy=0, sticky_v=0, res_count=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation: any buffered entries are discarded with no output. Handshakes in the reset cycle are ignored.
- Push: occurs when in_valid && in_ready. The entry {Z, V,P,Zr,CY,S} is written at the write pointer, and the write pointer toggles.
- Pop: occurs when out_valid && out_ready. The read pointer toggles.
- in_ready = (occupancy != 2). It is decoded from registered state only; there is no combinational path from out_ready. This is intentional, for timing isolation from the consumer.
- out_valid = (occupancy != 0). out_z/out_flags are driven from the entry at the read pointer. They stay stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - Occupancy 1: stays 1; the new entry becomes head on the next cycle.
  - Occupancy 2: no push is possible (in_ready=0); pop only.
- Empty: out_z/out_flags hold the last popped value (or 0 after reset) and are don't-care to the consumer.
- Latency: an entry pushed in cycle n is visible on out_* in cycle n+1 when the buffer was empty. There is no bypass.
- Throughput: 1 result/cycle sustained while out_ready=1.
- Sticky bits:
  - On a push with CY=1, sticky_cy sets next cycle. Same for V and sticky_v.
  - clr_sticky=1 clears both bits next cycle.
  - If a push with the flag set coincides with clr_sticky, set wins and the bit reads 1.
- Counter: res_count increments by 1 per push and wraps from 2^CNT_W-1 to 0. It is unaffected by clr_sticky.
- Flags are not recomputed: they are stored exactly as presented, including inconsistent combinations.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_W=16.
  - FLAG_W=5.
  - Flag bit indices: FLG_S=0, FLG_CY=1, FLG_ZR=2, FLG_P=3, FLG_V=4.
  - A packed alu_result_t {z, flags} used by this stage and the writeback consumer.
- One natural sub-module: skid_fifo2, a generic 2-entry valid/ready buffer of parameterised width. The top instantiates it with WIDTH+5 bits and adds the sticky and counter logic.

Test Plan:
- Reset then single push: push Z=16'h8000, S=1,CY=0,Zr=0,P=0,V=1 with out_ready=1 -> next cycle out_valid=1, out_z=16'h8000, out_flags=5'b10001; sticky_v=1, sticky_cy=0, res_count=1.
- Backpressure fill: out_ready=0, push 16'h0001 then 16'h0002 -> in_ready=0 after the 2nd push; a 3rd in_valid is not accepted; res_count=2. Raise out_ready -> outputs 0001 then 0002 in order, and in_ready returns to 1 after the first pop.
- Streaming: out_ready=1, push 10 consecutive results 0..9 -> outputs 0..9 one per cycle with 1-cycle latency; in_ready stays 1; res_count=10.
- Sticky priority: push with CY=1 and clr_sticky=1 in the same cycle -> sticky_cy=1. Next cycle clr_sticky=1 with no push -> sticky_cy=0, sticky_v=0.
- Counter wrap (CNT_W=8): 256 pushes -> res_count=0. A 257th push -> res_count=1.
- Reset mid-flight: buffer holding 2 entries, assert rst_n=0 for one edge -> out_valid=0, in_ready=1, res_count=0, sticky bits 0, and no stale entry emerges afterwards.
